// File: rtl/load_w_pkg.sv
// rtl/load_w_pkg.sv - shared state type and geometry helpers for the weight-buffer load packer
package load_w_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_e;

    function automatic int beats_per_row(input int data_width, input int beat_width);
        return data_width / beat_width;
    endfunction

    // A single-lane row still needs a 1-bit counter to keep the port widths legal.
    function automatic int lane_width(input int bpr);
        return (bpr > 1) ? $clog2(bpr) : 1;
    endfunction

endpackage

// File: rtl/w_row_assembler.sv
// rtl/w_row_assembler.sv - collects narrow beats into lanes of one buffer row
module w_row_assembler
    import load_w_pkg::*;
#(
    parameter int BEAT_WIDTH    = 512,
    parameter int BEATS_PER_ROW = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clear,
    input  logic                                beat_accept,
    input  logic [BEAT_WIDTH-1:0]               beat_data,
    output logic                                row_complete,
    output logic [BEATS_PER_ROW*BEAT_WIDTH-1:0] row_data
);

    localparam int LANE_W = lane_width(BEATS_PER_ROW);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BEATS_PER_ROW - 1);

    logic [LANE_W-1:0]     lane_q;
    logic [LANE_W-1:0]     lane_d;
    logic [BEAT_WIDTH-1:0] lanes_q [BEATS_PER_ROW];

    assign row_complete = beat_accept && (lane_q == LAST_LANE);

    always_comb begin
        lane_d = lane_q;
        if (clear || row_complete) begin
            lane_d = '0;
        end else if (beat_accept) begin
            lane_d = lane_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= '0;
        end else begin
            lane_q <= lane_d;
        end
    end

    // Lane payload needs no reset: a lane is always rewritten before it is read.
    always_ff @(posedge clk) begin
        if (beat_accept) begin
            lanes_q[lane_q] <= beat_data;
        end
    end

    // The last lane bypasses storage so the row is ready in the cycle of its final beat.
    always_comb begin
        row_data = '0;
        for (int k = 0; k < BEATS_PER_ROW; k++) begin
            if (k == BEATS_PER_ROW - 1) begin
                row_data[k*BEAT_WIDTH +: BEAT_WIDTH] = beat_data;
            end else begin
                row_data[k*BEAT_WIDTH +: BEAT_WIDTH] = lanes_q[k];
            end
        end
    end

endmodule

// File: rtl/load_w_packer.sv
// rtl/load_w_packer.sv - packs memory beats into weight-buffer rows and issues row writes
module load_w_packer
    import load_w_pkg::*;
#(
    parameter int BUFFER_ADDR_WIDTH = 13,
    parameter int BUFFER_DATA_WIDTH = 8192,
    parameter int BEAT_WIDTH        = 512,
    parameter int LEN_WIDTH         = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [BUFFER_ADDR_WIDTH-1:0] cmd_buffer_addr,
    input  logic [LEN_WIDTH-1:0]         cmd_row_count,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BEAT_WIDTH-1:0]        in_data,
    output logic                         load_write_addr_valid,
    output logic [BUFFER_ADDR_WIDTH-1:0] load_write_addr,
    output logic [BUFFER_DATA_WIDTH-1:0] load_write_data,
    output logic                         busy,
    output logic                         done
);

    localparam int BEATS_PER_ROW = beats_per_row(BUFFER_DATA_WIDTH, BEAT_WIDTH);

    state_e                         state_q, state_d;
    logic [BUFFER_ADDR_WIDTH-1:0]   row_addr_q, row_addr_d;
    logic [LEN_WIDTH-1:0]           rows_left_q, rows_left_d;
    logic                           wr_valid_q, wr_valid_d;
    logic [BUFFER_ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [BUFFER_DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;

    logic                           cmd_fire;
    logic                           beat_fire;
    logic                           row_complete;
    logic [BUFFER_DATA_WIDTH-1:0]   row_data;

    assign cmd_ready = ~rst && (state_q == ST_IDLE);
    assign in_ready  = ~rst && (state_q == ST_FILL);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign beat_fire = in_valid && in_ready;

    w_row_assembler #(
        .BEAT_WIDTH    (BEAT_WIDTH),
        .BEATS_PER_ROW (BEATS_PER_ROW)
    ) u_assembler (
        .clk          (clk),
        .rst          (rst),
        .clear        (cmd_fire),
        .beat_accept  (beat_fire),
        .beat_data    (in_data),
        .row_complete (row_complete),
        .row_data     (row_data)
    );

    always_comb begin
        state_d     = state_q;
        row_addr_d  = row_addr_q;
        rows_left_d = rows_left_q;
        wr_valid_d  = 1'b0;
        wr_addr_d   = '0;
        wr_data_d   = '0;
        done_d      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    row_addr_d  = cmd_buffer_addr;
                    rows_left_d = cmd_row_count;
                    if (cmd_row_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (row_complete) begin
                    wr_valid_d  = 1'b1;
                    wr_addr_d   = row_addr_q;
                    wr_data_d   = row_data;
                    row_addr_d  = row_addr_q + 1'b1;
                    rows_left_d = rows_left_q - 1'b1;
                    if (rows_left_q == LEN_WIDTH'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_FILL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            row_addr_q  <= '0;
            rows_left_q <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_addr_q  <= row_addr_d;
            rows_left_q <= rows_left_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign load_write_addr_valid = wr_valid_q;
    assign load_write_addr       = wr_addr_q;
    assign load_write_data       = wr_data_q;
    assign busy                  = busy_q;
    assign done                  = done_q;

endmodule

// File: tb/tb_load_w_packer.sv
// tb/tb_load_w_packer.sv - scoreboard bench for load_w_packer
module tb_load_w_packer;

    localparam int AW  = 13;
    localparam int DW  = 8192;
    localparam int BW  = 512;
    localparam int LW  = 16;
    localparam int BPR = DW / BW;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_buffer_addr;
    logic [LW-1:0] cmd_row_count;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic          load_write_addr_valid;
    logic [AW-1:0] load_write_addr;
    logic [DW-1:0] load_write_data;
    logic          busy;
    logic          done;

    load_w_packer #(
        .BUFFER_ADDR_WIDTH (AW),
        .BUFFER_DATA_WIDTH (DW),
        .BEAT_WIDTH        (BW),
        .LEN_WIDTH         (LW)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .cmd_valid             (cmd_valid),
        .cmd_ready             (cmd_ready),
        .cmd_buffer_addr       (cmd_buffer_addr),
        .cmd_row_count         (cmd_row_count),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .in_data               (in_data),
        .load_write_addr_valid (load_write_addr_valid),
        .load_write_addr       (load_write_addr),
        .load_write_data       (load_write_data),
        .busy                  (busy),
        .done                  (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit            is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            is_done;
        int            cyc;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    // Reference model: the command currently being filled
    logic [AW-1:0] m_addr;
    int            m_rows = 0;
    int            m_lane = 0;
    logic [DW-1:0] m_row;
    int            beat_idx = 0;
    int            last_wr_cyc = 0;
    int            gap_ph = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at cyc=%0d", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (load_write_addr_valid || done) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event actual valid=%0b done=%0b addr=0x%0h required=no event at cyc=%0d",
                         load_write_addr_valid, done, load_write_addr, cyc);
            end else begin
                e = exp_q.pop_front();
                if (load_write_addr_valid !== e.is_wr || done !== e.is_done || cyc != e.cyc ||
                    (e.is_wr && (load_write_addr !== e.addr || load_write_data !== e.data))) begin
                    failures++;
                    $display("FAIL event actual valid=%0b done=%0b addr=0x%0h cyc=%0d data_ok=%0b required valid=%0b done=%0b addr=0x%0h cyc=%0d",
                             load_write_addr_valid, done, load_write_addr, cyc,
                             load_write_data === e.data, e.is_wr, e.is_done, e.addr, e.cyc);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_event actual=none required valid=%0b done=%0b addr=0x%0h cyc=%0d",
                     e.is_wr, e.is_done, e.addr, e.cyc);
        end
        if (!load_write_addr_valid) begin
            checks++;
            if (load_write_addr !== '0 || load_write_data !== '0) begin
                failures++;
                $display("FAIL idle_outputs actual addr=0x%0h data_zero=%0b required addr=0 data_zero=1 at cyc=%0d",
                         load_write_addr, load_write_data == '0, cyc);
            end
        end
    end

    function automatic logic [BW-1:0] make_beat(input bit rnd, input int idx);
        logic [BW-1:0] b;
        for (int w = 0; w < BW / 32; w++) begin
            b[w*32 +: 32] = rnd ? $urandom : idx;
        end
        return b;
    endfunction

    // Offers a command from a negedge; returns at the negedge after its handshake.
    task automatic issue_cmd(input logic [AW-1:0] addr, input int cnt, output int hs_cyc);
        int budget = 0;
        cmd_valid       = 1'b1;
        cmd_buffer_addr = addr;
        cmd_row_count   = LW'(cnt);
        while (cmd_ready !== 1'b1 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 200) begin
            check("cmd_accept_timeout", 64'd0, 64'd1);
        end
        hs_cyc = cyc + 1;
        m_addr = addr;
        m_rows = cnt;
        m_lane = 0;
        if (cnt == 0) begin
            exp_q.push_back('{is_wr: 1'b0, addr: '0, data: '0, is_done: 1'b1, cyc: hs_cyc});
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // mode 0: in_valid always high, 1: pattern 1,0,0, 2: random
    task automatic feed(input int mode, input bit rnd, input int max_beats, input bit cmd_held);
        int budget   = 0;
        int accepted = 0;
        bit v;
        logic [BW-1:0] d;
        while (m_rows > 0 && accepted < max_beats && budget < 2000) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (gap_ph % 3 == 0) : 1'($urandom_range(0, 1));
            gap_ph++;
            d = make_beat(rnd, beat_idx);
            in_valid = v;
            in_data  = d;
            check("in_ready_in_fill", 64'(in_ready), 64'd1);
            if (cmd_held) begin
                check("cmd_ready_while_busy", 64'(cmd_ready), 64'd0);
            end
            if (v && in_ready) begin
                accepted++;
                beat_idx++;
                m_row[m_lane*BW +: BW] = d;
                m_lane++;
                if (m_lane == BPR) begin
                    exp_q.push_back('{is_wr: 1'b1, addr: m_addr, data: m_row,
                                      is_done: (m_rows == 1), cyc: cyc + 1});
                    last_wr_cyc = cyc + 1;
                    m_addr = m_addr + 1'b1;
                    m_rows--;
                    m_lane = 0;
                end
            end
            @(negedge clk);
            budget++;
        end
        in_valid = 1'b0;
        if (budget >= 2000) begin
            check("feed_timeout", 64'd0, 64'd1);
        end
    endtask

    initial begin
        int hs;
        int done_cyc;
        rst             = 1'b1;
        cmd_valid       = 1'b0;
        cmd_buffer_addr = '0;
        cmd_row_count   = '0;
        in_valid        = 1'b0;
        in_data         = '0;
        repeat (3) @(negedge clk);
        check("reset_cmd_ready", 64'(cmd_ready), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_valid", 64'(load_write_addr_valid), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", 64'(cmd_ready), 64'd1);

        // Two rows, continuous beats carrying their own index
        beat_idx = 0;
        issue_cmd(13'h010, 2, hs);
        check("busy_after_accept", 64'(busy), 64'd1);
        feed(0, 1'b0, 1000, 1'b0);
        check("busy_after_done", 64'(busy), 64'd0);

        // Same command with gaps in in_valid
        beat_idx = 0;
        gap_ph   = 0;
        issue_cmd(13'h010, 2, hs);
        feed(1, 1'b0, 1000, 1'b0);

        // Address wrap
        issue_cmd(13'h1FFF, 2, hs);
        feed(0, 1'b1, 1000, 1'b0);

        // Zero-length command; beats offered in IDLE must be refused
        issue_cmd(13'h055, 0, hs);
        in_valid = 1'b1;
        in_data  = make_beat(1'b1, 0);
        check("zero_len_in_ready", 64'(in_ready), 64'd0);
        check("zero_len_busy", 64'(busy), 64'd0);
        repeat (2) begin
            @(negedge clk);
            check("idle_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;

        // Reset part-way through a row
        issue_cmd(13'h100, 1, hs);
        feed(0, 1'b1, 7, 1'b0);
        rst = 1'b1;
        m_rows = 0;
        m_lane = 0;
        @(negedge clk);
        check("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_valid", 64'(load_write_addr_valid), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        issue_cmd(13'h020, 1, hs);
        feed(0, 1'b1, 1000, 1'b0);

        // Second command held while the first is busy
        issue_cmd(13'h300, 1, hs);
        cmd_valid       = 1'b1;
        cmd_buffer_addr = 13'h400;
        cmd_row_count   = LW'(1);
        feed(0, 1'b1, 1000, 1'b1);
        done_cyc = cyc;
        check("held_cmd_ready_at_done", 64'(cmd_ready), 64'd1);
        issue_cmd(13'h400, 1, hs);
        check("held_cmd_accept_cyc", 64'(hs), 64'(done_cyc + 1));
        feed(0, 1'b1, 1000, 1'b0);
        check("held_first_write_gap", 64'(last_wr_cyc - done_cyc), 64'd17);

        // Randomized commands
        for (int n = 0; n < 5; n++) begin
            issue_cmd(AW'($urandom), $urandom_range(0, 3), hs);
            feed(2, 1'b1, 1000, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
